// File: rtl/demux_1to4.sv
// Registered 1-to-4 demultiplexer: steers I onto one of four lanes by {S1,S0}.
// Unselected lanes read 0; sel_q tags which lane the current Y values belong to.
module demux_1to4 #(
  parameter int WIDTH   = 1,
  parameter bit OUT_REG = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] I,
  input  logic             S0,
  input  logic             S1,
  output logic [WIDTH-1:0] Y0,
  output logic [WIDTH-1:0] Y1,
  output logic [WIDTH-1:0] Y2,
  output logic [WIDTH-1:0] Y3,
  output logic [1:0]       sel_q
);

  logic [1:0]       sel;
  logic [WIDTH-1:0] y0_d;
  logic [WIDTH-1:0] y1_d;
  logic [WIDTH-1:0] y2_d;
  logic [WIDTH-1:0] y3_d;

  assign sel = {S1, S0};

  // One-hot decode: exactly one lane may see I, the rest are forced to 0
  always_comb begin
    y0_d = '0;
    y1_d = '0;
    y2_d = '0;
    y3_d = '0;
    unique case (sel)
      2'b00:   y0_d = I;
      2'b01:   y1_d = I;
      2'b10:   y2_d = I;
      default: y3_d = I;
    endcase
  end

  // Lane tag is registered in both modes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sel_q <= 2'b00;
    else     sel_q <= sel;
  end

  if (OUT_REG) begin : g_reg
    logic [WIDTH-1:0] y0_q;
    logic [WIDTH-1:0] y1_q;
    logic [WIDTH-1:0] y2_q;
    logic [WIDTH-1:0] y3_q;

    // Output register: whole lane set updates on one edge, so no glitches
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        y0_q <= '0;
        y1_q <= '0;
        y2_q <= '0;
        y3_q <= '0;
      end else begin
        y0_q <= y0_d;
        y1_q <= y1_d;
        y2_q <= y2_d;
        y3_q <= y3_d;
      end
    end

    assign Y0 = y0_q;
    assign Y1 = y1_q;
    assign Y2 = y2_q;
    assign Y3 = y3_q;
  end else begin : g_comb
    // Zero-latency path; reset still clears the lanes immediately
    assign Y0 = rst ? '0 : y0_d;
    assign Y1 = rst ? '0 : y1_d;
    assign Y2 = rst ? '0 : y2_d;
    assign Y3 = rst ? '0 : y3_d;
  end

endmodule

// File: tb/tb_demux_1to4.sv
// Bench for demux_1to4: registered 1-bit, registered 8-bit and combinational
// instances, directed scenarios plus random traffic against a lane model.
module tb_demux_1to4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       m_I, m_S0, m_S1;
  logic       m_Y0, m_Y1, m_Y2, m_Y3;
  logic [1:0] m_selq;

  logic [7:0] w_I;
  logic       w_S0, w_S1;
  logic [7:0] w_Y0, w_Y1, w_Y2, w_Y3;
  logic [1:0] w_selq;

  logic       c_I, c_S0, c_S1;
  logic       c_Y0, c_Y1, c_Y2, c_Y3;
  logic [1:0] c_selq;

  int n_checks = 0;
  int n_fail   = 0;
  int glitches = 0;

  demux_1to4 #(.WIDTH(1), .OUT_REG(1'b1)) u_main (
    .clk(clk), .rst(rst), .I(m_I), .S0(m_S0), .S1(m_S1),
    .Y0(m_Y0), .Y1(m_Y1), .Y2(m_Y2), .Y3(m_Y3), .sel_q(m_selq));

  demux_1to4 #(.WIDTH(8), .OUT_REG(1'b1)) u_wide (
    .clk(clk), .rst(rst), .I(w_I), .S0(w_S0), .S1(w_S1),
    .Y0(w_Y0), .Y1(w_Y1), .Y2(w_Y2), .Y3(w_Y3), .sel_q(w_selq));

  demux_1to4 #(.WIDTH(1), .OUT_REG(1'b0)) u_comb (
    .clk(clk), .rst(rst), .I(c_I), .S0(c_S0), .S1(c_S1),
    .Y0(c_Y0), .Y1(c_Y1), .Y2(c_Y2), .Y3(c_Y3), .sel_q(c_selq));

  wire [3:0]  m_y = {m_Y3, m_Y2, m_Y1, m_Y0};
  wire [31:0] w_y = {w_Y3, w_Y2, w_Y1, w_Y0};
  wire [3:0]  c_y = {c_Y3, c_Y2, c_Y1, c_Y0};

  // More than one live lane at any instant on the combinational path
  always @(c_Y0 or c_Y1 or c_Y2 or c_Y3)
    if ($countones({c_Y3, c_Y2, c_Y1, c_Y0}) > 1) glitches++;

  // Model: lane k occupies bits [k*W +: W]; data lands at lane number sel
  function automatic logic [3:0] lanes1(logic i, logic [1:0] s);
    return 4'(i) << s;
  endfunction

  function automatic logic [31:0] lanes8(logic [7:0] i, logic [1:0] s);
    return 32'(i) << (8 * s);
  endfunction

  task automatic drive_m(logic i, logic [1:0] s);
    m_I = i; {m_S1, m_S0} = s;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive_m(1'b1, 2'b10);
    w_I = 8'hFF; {w_S1, w_S0} = 2'b10;
    c_I = 1'b1;  {c_S1, c_S0} = 2'b10;
    #2;
    n_checks++;
    if (m_y !== 4'b0000) begin
      n_fail++; $display("FAIL reset_y: got %b expected 0000", m_y);
    end
    n_checks++;
    if (m_selq !== 2'b00) begin
      n_fail++; $display("FAIL reset_selq: got %b expected 00", m_selq);
    end
    n_checks++;
    if (w_y !== 32'h0) begin
      n_fail++; $display("FAIL reset_wide: got %h expected 0", w_y);
    end
    n_checks++;
    if (c_y !== 4'b0000) begin
      n_fail++; $display("FAIL reset_comb: got %b expected 0000", c_y);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_sweep;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      drive_m(1'b1, 2'(s));
      @(posedge clk); #1;
      n_checks++;
      if (m_y !== lanes1(1'b1, 2'(s)) || m_selq !== 2'(s)) begin
        n_fail++;
        $display("FAIL sweep_sel%0d: got y=%b sel_q=%b expected y=%b sel_q=%b",
                 s, m_y, m_selq, lanes1(1'b1, 2'(s)), 2'(s));
      end
    end
  endtask

  task automatic test_zero;
    @(negedge clk);
    drive_m(1'b0, 2'b00);
    @(posedge clk); #1;
    n_checks++;
    if (m_y !== 4'b0000 || m_selq !== 2'b00) begin
      n_fail++;
      $display("FAIL zero_data: got y=%b sel_q=%b expected y=0000 sel_q=00",
               m_y, m_selq);
    end
  endtask

  task automatic test_wide;
    @(negedge clk);
    w_I = 8'hA5; {w_S1, w_S0} = 2'b11;
    @(posedge clk); #1;
    n_checks++;
    if (w_y !== 32'hA500_0000 || w_selq !== 2'b11) begin
      n_fail++;
      $display("FAIL wide_a5: got y=%h sel_q=%b expected y=a5000000 sel_q=11",
               w_y, w_selq);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    drive_m(1'b1, 2'b10);
    @(posedge clk); #1;
    n_checks++;
    if (m_y !== 4'b0100) begin
      n_fail++; $display("FAIL rmid_load: got %b expected 0100", m_y);
    end
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (m_y !== 4'b0000 || m_selq !== 2'b00) begin
      n_fail++;
      $display("FAIL rmid_async: got y=%b sel_q=%b expected 0000/00",
               m_y, m_selq);
    end
    @(posedge clk); #1;
    n_checks++;
    if (m_y !== 4'b0000) begin
      n_fail++; $display("FAIL rmid_hold: got %b expected 0000", m_y);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (m_y !== 4'b0000) begin
      n_fail++; $display("FAIL rmid_noedge: got %b expected 0000", m_y);
    end
    @(posedge clk); #1;
    n_checks++;
    if (m_y !== 4'b0100 || m_selq !== 2'b10) begin
      n_fail++;
      $display("FAIL rmid_reload: got y=%b sel_q=%b expected 0100/10",
               m_y, m_selq);
    end
  endtask

  task automatic test_comb;
    @(negedge clk);
    c_I = 1'b1; {c_S1, c_S0} = 2'b01;
    #1;
    n_checks++;
    if (c_y !== 4'b0010) begin
      n_fail++; $display("FAIL comb_sel01: got %b expected 0010", c_y);
    end
    glitches = 0;
    {c_S1, c_S0} = 2'b10;
    #1;
    n_checks++;
    if (c_y !== 4'b0100) begin
      n_fail++; $display("FAIL comb_sel10: got %b expected 0100", c_y);
    end
    n_checks++;
    if (glitches !== 0) begin
      n_fail++; $display("FAIL comb_onehot: got %0d overlaps expected 0", glitches);
    end
    @(posedge clk); #1;
    n_checks++;
    if (c_selq !== 2'b10) begin
      n_fail++; $display("FAIL comb_selq: got %b expected 10", c_selq);
    end
  endtask

  task automatic test_random;
    logic       r, mi, ci;
    logic [7:0] wi;
    logic [1:0] ms, ws, cs;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      r  = ($urandom_range(0, 11) == 0);
      mi = 1'($urandom); ms = 2'($urandom);
      wi = 8'($urandom); ws = 2'($urandom);
      ci = 1'($urandom); cs = 2'($urandom);
      rst = r;
      drive_m(mi, ms);
      w_I = wi; {w_S1, w_S0} = ws;
      c_I = ci; {c_S1, c_S0} = cs;
      #1;
      n_checks++;
      if (c_y !== (r ? 4'b0 : lanes1(ci, cs))) begin
        n_fail++;
        $display("FAIL rand_comb[%0d]: got %b expected %b",
                 n, c_y, r ? 4'b0 : lanes1(ci, cs));
      end
      @(posedge clk); #1;
      n_checks++;
      if (m_y !== (r ? 4'b0 : lanes1(mi, ms)) || m_selq !== (r ? 2'b0 : ms)) begin
        n_fail++;
        $display("FAIL rand_main[%0d]: got y=%b sel_q=%b expected y=%b sel_q=%b",
                 n, m_y, m_selq, r ? 4'b0 : lanes1(mi, ms), r ? 2'b0 : ms);
      end
      n_checks++;
      if (w_y !== (r ? 32'h0 : lanes8(wi, ws)) || w_selq !== (r ? 2'b0 : ws)) begin
        n_fail++;
        $display("FAIL rand_wide[%0d]: got y=%h sel_q=%b expected y=%h sel_q=%b",
                 n, w_y, w_selq, r ? 32'h0 : lanes8(wi, ws), r ? 2'b0 : ws);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    test_reset;
    test_sweep;
    test_zero;
    test_wide;
    test_reset_mid;
    test_comb;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
